// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Ethernet/ARP framing constants shared by the ARP receive and transmit paths
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  localparam logic [47:0] MAC_BCAST    = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ARP_OP_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY = 16'h0002;
  localparam int          ETH_HEAD_LEN = 14;
  localparam int          ARP_LEN      = 28;

endpackage

// File: rtl/arp_rx.sv
// rtl/arp_rx.sv - GMII ARP receiver: parses and filters ARP frames, reports sender addresses
module arp_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_ETH_HEAD,
    S_ARP_DATA,
    S_RX_END
  } state_t;

  localparam logic [4:0] PRE_MIN  = 5'd6;
  localparam logic [4:0] PRE_MAX  = 5'd7;
  localparam logic [4:0] HEAD_END = 5'(ETH_HEAD_LEN - 1);
  localparam logic [4:0] ARP_END  = 5'(ARP_LEN - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic        dv_r;
  logic [7:0]  rxd_r;
  logic [47:0] da_reg;
  logic [7:0]  etype_hi;
  logic [15:0] op_reg;
  logic [47:0] smac_reg;
  logic [31:0] sip_reg;
  logic [23:0] tip_reg;

  logic da_ok;
  logic type_ok;
  logic op_ok;
  logic tip_ok;

  assign da_ok   = (da_reg == BOARD_MAC) || (da_reg == MAC_BCAST);
  assign type_ok = ({etype_hi, rxd_r} == ETH_TYPE_ARP);
  assign op_ok   = (op_reg == ARP_OP_REQ) || (op_reg == ARP_OP_REPLY);
  // Target IP is only complete once its last byte sits in rxd_r.
  assign tip_ok  = ({tip_reg, rxd_r} == BOARD_IP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 5'd0;
      dv_r        <= 1'b0;
      rxd_r       <= 8'd0;
      da_reg      <= 48'd0;
      etype_hi    <= 8'd0;
      op_reg      <= 16'd0;
      smac_reg    <= 48'd0;
      sip_reg     <= 32'd0;
      tip_reg     <= 24'd0;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= 48'd0;
      src_ip      <= 32'd0;
    end else begin
      dv_r        <= gmii_rx_dv;
      rxd_r       <= gmii_rxd;
      arp_rx_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (dv_r && rxd_r == ETH_PREAMBLE) begin
            state <= S_PREAMBLE;
            cnt   <= 5'd1;
          end
        end

        S_PREAMBLE: begin
          if (!dv_r) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
          end else if (rxd_r == ETH_PREAMBLE) begin
            if (cnt == PRE_MAX) begin
              state <= S_RX_END;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end else if (rxd_r == ETH_SFD && cnt >= PRE_MIN && cnt <= PRE_MAX) begin
            state <= S_ETH_HEAD;
            cnt   <= 5'd0;
          end else begin
            state <= S_RX_END;
            cnt   <= 5'd0;
          end
        end

        S_ETH_HEAD: begin
          if (!dv_r) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
          end else begin
            if (cnt < 5'd6) da_reg <= {da_reg[39:0], rxd_r};
            if (cnt == 5'd12) etype_hi <= rxd_r;
            if (cnt == HEAD_END) begin
              state <= (da_ok && type_ok) ? S_ARP_DATA : S_RX_END;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end

        S_ARP_DATA: begin
          if (!dv_r) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
          end else begin
            if (cnt >= 5'd6 && cnt <= 5'd7)   op_reg   <= {op_reg[7:0], rxd_r};
            if (cnt >= 5'd8 && cnt <= 5'd13)  smac_reg <= {smac_reg[39:0], rxd_r};
            if (cnt >= 5'd14 && cnt <= 5'd17) sip_reg  <= {sip_reg[23:0], rxd_r};
            if (cnt >= 5'd24 && cnt <= 5'd26) tip_reg  <= {tip_reg[15:0], rxd_r};
            if (cnt == ARP_END) begin
              if (tip_ok && op_ok) begin
                arp_rx_done <= 1'b1;
                arp_rx_type <= (op_reg == ARP_OP_REPLY);
                src_mac     <= smac_reg;
                src_ip      <= sip_reg;
              end
              state <= S_RX_END;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end

        S_RX_END: begin
          if (!dv_r) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= 5'd0;
        end
      endcase
    end
  end

endmodule
